// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI4 widths, enums, write-master FSM states and the
//                burst-legality function used by AXI initiators.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam int AXI_ADDR_WIDTH  = 32;
    localparam int AXI_DATA_WIDTH  = 32;
    localparam int AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8;
    localparam int AXI_LEN_WIDTH   = 8;
    localparam int AXI_SIZE_WIDTH  = 3;
    localparam int AXI_BURST_WIDTH = 2;

    typedef enum logic [AXI_SIZE_WIDTH-1:0] {
        ONE_BYTE               = 3'd0,
        TWO_BYTES              = 3'd1,
        FOUR_BYTES             = 3'd2,
        EIGHT_BYTES            = 3'd3,
        SIXTEEN_BYTES          = 3'd4,
        THIRTY_TWO_BYTES       = 3'd5,
        SIXTY_FOUR_BYTES       = 3'd6,
        ONE_TWENTY_EIGHT_BYTES = 3'd7
    } size_enum_t;

    typedef enum logic [AXI_BURST_WIDTH-1:0] {
        BURST_FIXED    = 2'b00,
        BURST_INCR     = 2'b01,
        BURST_WRAP     = 2'b10,
        BURST_RESERVED = 2'b11
    } burst_enum_t;

    typedef logic [1:0] resp_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_enum_t;

    typedef enum logic [2:0] {
        WR_IDLE  = 3'd0,
        WR_CHECK = 3'd1,
        WR_ADDR  = 3'd2,
        WR_DATA  = 3'd3,
        WR_RESP  = 3'd4,
        WR_DONE  = 3'd5
    } wr_mst_state_t;

    // Returns 1 when the burst must not be put on the bus.
    function automatic logic axi_burst_illegal(
        input logic [AXI_ADDR_WIDTH-1:0]  addr,
        input logic [AXI_LEN_WIDTH-1:0]   len,
        input logic [AXI_SIZE_WIDTH-1:0]  size,
        input logic [AXI_BURST_WIDTH-1:0] burst,
        input logic [AXI_ADDR_WIDTH-1:0]  boundary
    );
        logic [AXI_ADDR_WIDTH:0]   w_span;
        logic [AXI_ADDR_WIDTH:0]   w_end;
        logic [AXI_ADDR_WIDTH-1:0] w_bmask;
        logic [AXI_ADDR_WIDTH-1:0] w_amask;
        logic [7:0]                w_nbytes;
        logic                      w_err;

        w_err    = 1'b0;
        w_nbytes = 8'd1 << size;
        w_amask  = AXI_ADDR_WIDTH'(w_nbytes) - AXI_ADDR_WIDTH'(1);
        // Total burst span in bytes; one extra bit catches address-space wrap.
        w_span   = (AXI_ADDR_WIDTH+1)'(len) + (AXI_ADDR_WIDTH+1)'(1);
        w_span   = w_span << size;
        w_end    = {1'b0, addr} + w_span - (AXI_ADDR_WIDTH+1)'(1);
        w_bmask  = ~(boundary - AXI_ADDR_WIDTH'(1));

        if (burst == BURST_RESERVED) begin
            w_err = 1'b1;
        end
        if (w_nbytes > 8'(AXI_STRB_WIDTH)) begin
            w_err = 1'b1;
        end
        if (burst == BURST_WRAP) begin
            if (!(len == AXI_LEN_WIDTH'(1) || len == AXI_LEN_WIDTH'(3) ||
                  len == AXI_LEN_WIDTH'(7) || len == AXI_LEN_WIDTH'(15))) begin
                w_err = 1'b1;
            end
            if ((addr & w_amask) != '0) begin
                w_err = 1'b1;
            end
        end
        if (burst == BURST_INCR) begin
            if (w_end[AXI_ADDR_WIDTH]) begin
                w_err = 1'b1;
            end
            if (((addr ^ w_end[AXI_ADDR_WIDTH-1:0]) & w_bmask) != '0) begin
                w_err = 1'b1;
            end
        end
        return w_err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_check.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_check
//  Description : Combinational AXI4 burst legality check (reserved burst,
//                illegal WRAP, oversize beat, INCR boundary/overflow).
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_check
    import axi_pkg::*;
#(
    parameter int unsigned BOUNDARY_BYTES = 4096,
    parameter bit          CHECK_EN       = 1'b1
) (
    input  logic [AXI_ADDR_WIDTH-1:0]  addr,
    input  logic [AXI_LEN_WIDTH-1:0]   len,
    input  logic [AXI_SIZE_WIDTH-1:0]  size,
    input  logic [AXI_BURST_WIDTH-1:0] burst,
    output logic                       err
);

    generate
        if (CHECK_EN) begin : g_check
            assign err = axi_burst_illegal(addr, len, size, burst,
                                           AXI_ADDR_WIDTH'(BOUNDARY_BYTES));
        end else begin : g_bypass
            // Every command goes to the bus when checking is disabled.
            assign err = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/axi_wr_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi_wr_master
//  Description : AXI4 write-channel initiator. Takes one burst command and a
//                beat stream, drives AW/W/B, reports the write response.
//                One transaction outstanding at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_master
    import axi_pkg::*;
#(
    parameter int unsigned BOUNDARY_BYTES = 4096,
    parameter bit          CHECK_EN       = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    // Command
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [AXI_LEN_WIDTH-1:0]   cmd_len,
    input  logic [AXI_SIZE_WIDTH-1:0]  cmd_size,
    input  logic [AXI_BURST_WIDTH-1:0] cmd_burst,
    // Beat stream
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [AXI_DATA_WIDTH-1:0]  wr_data,
    input  logic [AXI_STRB_WIDTH-1:0]  wr_strb,
    // AW
    output logic [AXI_ADDR_WIDTH-1:0]  awaddr,
    output logic [AXI_LEN_WIDTH-1:0]   awlen,
    output logic [AXI_SIZE_WIDTH-1:0]  awsize,
    output logic [AXI_BURST_WIDTH-1:0] awburst,
    output logic                       awvalid,
    input  logic                       awready,
    // W
    output logic [AXI_DATA_WIDTH-1:0]  wdata,
    output logic [AXI_STRB_WIDTH-1:0]  wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,
    // B
    input  logic [1:0]                 bresp,
    input  logic                       bvalid,
    output logic                       bready,
    // Completion
    output logic                       done_valid,
    output logic [1:0]                 done_resp
);

    wr_mst_state_t              r_state;
    wr_mst_state_t              w_state_next;

    logic [AXI_ADDR_WIDTH-1:0]  r_awaddr;
    logic [AXI_LEN_WIDTH-1:0]   r_awlen;
    logic [AXI_SIZE_WIDTH-1:0]  r_awsize;
    logic [AXI_BURST_WIDTH-1:0] r_awburst;
    logic [AXI_LEN_WIDTH-1:0]   r_count;
    resp_t                      r_done_resp;
    logic                       w_err;

    assign awaddr    = r_awaddr;
    assign awlen     = r_awlen;
    assign awsize    = r_awsize;
    assign awburst   = r_awburst;
    assign wdata     = wr_data;
    assign wstrb     = wr_strb;
    assign done_resp = r_done_resp;

    axi_burst_check #(
        .BOUNDARY_BYTES (BOUNDARY_BYTES),
        .CHECK_EN       (CHECK_EN)
    ) u_burst_check (
        .addr  (r_awaddr),
        .len   (r_awlen),
        .size  (r_awsize),
        .burst (r_awburst),
        .err   (w_err)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        wr_ready     = 1'b0;
        wlast        = 1'b0;
        bready       = 1'b0;
        done_valid   = 1'b0;
        case (r_state)
            WR_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    w_state_next = WR_CHECK;
                end
            end
            WR_CHECK: begin
                w_state_next = w_err ? WR_DONE : WR_ADDR;
            end
            WR_ADDR: begin
                awvalid = 1'b1;
                if (awready) begin
                    w_state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                // Stream and bus stalls both simply hold the beat in place.
                wvalid   = wr_valid;
                wr_ready = wready;
                wlast    = (r_count == r_awlen);
                if (wr_valid && wready && wlast) begin
                    w_state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_state_next = WR_DONE;
                end
            end
            WR_DONE: begin
                done_valid   = 1'b1;
                w_state_next = WR_IDLE;
            end
            default: begin
                w_state_next = WR_IDLE;
            end
        endcase
    end

    // Command latch, beat counter and completion response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_awaddr    <= '0;
            r_awlen     <= '0;
            r_awsize    <= '0;
            r_awburst   <= '0;
            r_count     <= '0;
            r_done_resp <= '0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                r_awaddr  <= cmd_addr;
                r_awlen   <= cmd_len;
                r_awsize  <= cmd_size;
                r_awburst <= cmd_burst;
                r_count   <= '0;
            end
            if (wvalid && wready) begin
                r_count <= r_count + 1'b1;
            end
            if (r_state == WR_CHECK && w_err) begin
                r_done_resp <= RESP_SLVERR;
            end
            if (bready && bvalid) begin
                r_done_resp <= bresp;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_wr_master
//  Description : Scoreboard bench for axi_wr_master with a responsive AXI
//                slave model and a beat-stream source.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_wr_master;
    import axi_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       cmd_valid = 1'b0;
    logic                       cmd_ready;
    logic [AXI_ADDR_WIDTH-1:0]  cmd_addr = '0;
    logic [AXI_LEN_WIDTH-1:0]   cmd_len = '0;
    logic [AXI_SIZE_WIDTH-1:0]  cmd_size = '0;
    logic [AXI_BURST_WIDTH-1:0] cmd_burst = '0;
    logic                       wr_valid = 1'b0;
    logic                       wr_ready;
    logic [AXI_DATA_WIDTH-1:0]  wr_data = '0;
    logic [AXI_STRB_WIDTH-1:0]  wr_strb = '0;
    logic [AXI_ADDR_WIDTH-1:0]  awaddr;
    logic [AXI_LEN_WIDTH-1:0]   awlen;
    logic [AXI_SIZE_WIDTH-1:0]  awsize;
    logic [AXI_BURST_WIDTH-1:0] awburst;
    logic                       awvalid;
    logic                       awready;
    logic [AXI_DATA_WIDTH-1:0]  wdata;
    logic [AXI_STRB_WIDTH-1:0]  wstrb;
    logic                       wlast;
    logic                       wvalid;
    logic                       wready;
    logic [1:0]                 bresp;
    logic                       bvalid;
    logic                       bready;
    logic                       done_valid;
    logic [1:0]                 done_resp;

    axi_wr_master #(
        .BOUNDARY_BYTES (4096),
        .CHECK_EN       (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_strb    (wr_strb),
        .awaddr     (awaddr),
        .awlen      (awlen),
        .awsize     (awsize),
        .awburst    (awburst),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wlast      (wlast),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .done_valid (done_valid),
        .done_resp  (done_resp)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } aw_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_exp_t;

    typedef struct {
        logic [1:0] resp;
        int         cyc;
    } done_exp_t;

    aw_exp_t   exp_aw[$];
    w_exp_t    exp_w[$];
    done_exp_t exp_done[$];

    int         n_checks    = 0;
    int         n_fails     = 0;
    int         cyc         = 0;
    int         done_seen   = 0;
    int         w_hs_count  = 0;
    int         b_req       = 0;
    bit         aw_seen     = 1'b0;
    int         aw_delay    = 0;
    int         w_stall_beat = -1;
    int         w_stall_len = 0;
    logic [1:0] slave_bresp = 2'b00;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] strb_of(input int i);
        return 4'hF >> (i % 4);
    endfunction

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // AW slave: raise awready after aw_delay cycles of awvalid.
    initial begin
        int waited;
        waited  = 0;
        awready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (awvalid) begin
                awready = (waited >= aw_delay);
                waited++;
            end else begin
                awready = 1'b0;
                waited  = 0;
            end
        end
    end

    // W slave: optionally stall a chosen beat for a number of cycles.
    initial begin
        int stalled;
        stalled = 0;
        wready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rst || done_valid) stalled = 0;
            if (w_hs_count == w_stall_beat && stalled < w_stall_len) begin
                wready = 1'b0;
                stalled++;
            end else begin
                wready = 1'b1;
            end
        end
    end

    // B slave: one response per completed last beat.
    initial begin
        int served;
        bit hs;
        served = 0;
        bvalid = 1'b0;
        bresp  = 2'b00;
        forever begin
            @(negedge clk);
            hs = bvalid && bready;
            @(posedge clk);
            #1;
            if (hs || rst) bvalid = 1'b0;
            if (!bvalid && b_req > served) begin
                bvalid = 1'b1;
                bresp  = slave_bresp;
                served++;
            end
        end
    end

    // Monitor: compares bus activity and completions against the scoreboard.
    initial begin
        aw_exp_t   ea;
        w_exp_t    ew;
        done_exp_t ed;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_seen    = 1'b0;
                w_hs_count = 0;
            end else begin
                if (awvalid) begin
                    chk_eq("aw_expected", exp_aw.size() > 0, 1'b1);
                    if (exp_aw.size() > 0) begin
                        ea = exp_aw[0];
                        chk_eq("awaddr", awaddr, ea.addr);
                        chk_eq("awlen", awlen, ea.len);
                        chk_eq("awsize", awsize, ea.size);
                        chk_eq("awburst", awburst, ea.burst);
                        if (awready) begin
                            void'(exp_aw.pop_front());
                            aw_seen = 1'b1;
                        end
                    end
                end
                if (wvalid && wready) begin
                    chk_eq("w_after_aw", aw_seen, 1'b1);
                    chk_eq("w_expected", exp_w.size() > 0, 1'b1);
                    if (exp_w.size() > 0) begin
                        ew = exp_w.pop_front();
                        chk_eq("wdata", wdata, ew.data);
                        chk_eq("wstrb", wstrb, ew.strb);
                        chk_eq("wlast", wlast, ew.last);
                    end
                    w_hs_count++;
                    if (wlast) b_req++;
                end
                if (done_valid) begin
                    chk_eq("done_expected", exp_done.size() > 0, 1'b1);
                    if (exp_done.size() > 0) begin
                        ed = exp_done.pop_front();
                        chk_eq("done_resp", done_resp, ed.resp);
                        if (ed.cyc >= 0) chk_eq("done_latency", cyc, ed.cyc);
                    end
                    done_seen++;
                    aw_seen    = 1'b0;
                    w_hs_count = 0;
                end
            end
        end
    end

    task automatic issue_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b, output int hc);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_burst = b;
        hc        = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready) hc = cyc;
            @(posedge clk);
            #1;
            if (hc >= 0) break;
        end
        cmd_valid = 1'b0;
        chk_eq("cmd_accept", hc >= 0, 1'b1);
    endtask

    task automatic send_beats(input int n, input logic [31:0] base, input int gap);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 1) begin
                wr_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            wr_valid = 1'b1;
            wr_data  = base + 32'(i);
            wr_strb  = strb_of(i);
            ok = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                ok = wr_ready;
                @(posedge clk);
                #1;
                if (ok) break;
            end
            chk_eq("beat_accept", ok, 1'b1);
        end
        wr_valid = 1'b0;
    endtask

    task automatic push_expect(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                               input logic [1:0] b, input logic [31:0] base, input int nbeats);
        aw_exp_t ea;
        w_exp_t  ew;
        ea.addr  = a;
        ea.len   = l;
        ea.size  = s;
        ea.burst = b;
        exp_aw.push_back(ea);
        for (int i = 0; i < nbeats; i++) begin
            ew.data = base + 32'(i);
            ew.strb = strb_of(i);
            ew.last = (i == int'(l));
            exp_w.push_back(ew);
        end
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input bit exp_err, input logic [31:0] base,
                           input int gap, input bit timed, input logic [1:0] resp);
        int        hc;
        int        tgt;
        done_exp_t ed;
        tgt = done_seen + 1;
        if (!exp_err) push_expect(a, l, s, b, base, int'(l) + 1);
        issue_cmd(a, l, s, b, hc);
        ed.resp = exp_err ? 2'b10 : resp;
        ed.cyc  = timed ? (hc + (exp_err ? 2 : 5 + int'(l))) : -1;
        exp_done.push_back(ed);
        if (!exp_err) send_beats(int'(l) + 1, base, gap);
        for (int k = 0; k < 300 && done_seen < tgt; k++) begin
            @(posedge clk);
            #1;
        end
        chk_eq("done_arrived", done_seen >= tgt, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hc;
        int saved;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_eq("rst_cmd_ready", cmd_ready, 1'b0);
        chk_eq("rst_awvalid", awvalid, 1'b0);
        chk_eq("rst_wvalid", wvalid, 1'b0);
        chk_eq("rst_wr_ready", wr_ready, 1'b0);
        chk_eq("rst_bready", bready, 1'b0);
        chk_eq("rst_done_valid", done_valid, 1'b0);
        chk_eq("rst_done_resp", done_resp, 2'b00);
        chk_eq("rst_awaddr", awaddr, 32'h0);
        chk_eq("rst_awlen", awlen, 8'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_eq("idle_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;

        // Zero-wait INCR, 4 beats, 8-cycle latency.
        run_txn(32'h100, 8'd3, FOUR_BYTES, BURST_INCR, 1'b0, 32'hA000_0000, 0, 1'b1, 2'b00);

        // Same burst with AW delay, W stall on beat 1 and stream gaps.
        aw_delay = 5; w_stall_beat = 1; w_stall_len = 3;
        run_txn(32'h100, 8'd3, FOUR_BYTES, BURST_INCR, 1'b0, 32'hB000_0000, 2, 1'b0, 2'b00);
        aw_delay = 0; w_stall_beat = -1; w_stall_len = 0;

        // 0xFF8 + 16 bytes crosses 0x1000.
        run_txn(32'hFF8, 8'd3, FOUR_BYTES, BURST_INCR, 1'b1, 32'h0, 0, 1'b1, 2'b10);
        // Ends exactly at 0xFFF: legal.
        run_txn(32'hFF0, 8'd3, FOUR_BYTES, BURST_INCR, 1'b0, 32'hC000_0000, 0, 1'b1, 2'b00);
        // WRAP with 3 beats.
        run_txn(32'h100, 8'd2, FOUR_BYTES, BURST_WRAP, 1'b1, 32'h0, 0, 1'b1, 2'b10);
        // Legal WRAP.
        run_txn(32'h104, 8'd3, FOUR_BYTES, BURST_WRAP, 1'b0, 32'hD000_0000, 0, 1'b1, 2'b00);
        // Misaligned WRAP.
        run_txn(32'h102, 8'd3, FOUR_BYTES, BURST_WRAP, 1'b1, 32'h0, 0, 1'b1, 2'b10);
        // Reserved burst type.
        run_txn(32'h100, 8'd1, FOUR_BYTES, BURST_RESERVED, 1'b1, 32'h0, 0, 1'b1, 2'b10);
        // 8-byte beats on a 4-byte bus.
        run_txn(32'h100, 8'd0, EIGHT_BYTES, BURST_INCR, 1'b1, 32'h0, 0, 1'b1, 2'b10);
        // Address-space overflow.
        run_txn(32'hFFFF_FFFC, 8'd1, FOUR_BYTES, BURST_INCR, 1'b1, 32'h0, 0, 1'b1, 2'b10);
        // Single beat: wlast on first beat, 5-cycle latency.
        run_txn(32'h200, 8'd0, FOUR_BYTES, BURST_INCR, 1'b0, 32'hE000_0000, 0, 1'b1, 2'b00);
        // FIXED burst passed through unchanged.
        run_txn(32'h300, 8'd1, TWO_BYTES, BURST_FIXED, 1'b0, 32'hF000_0000, 0, 1'b1, 2'b00);
        // Slave error response forwarded.
        slave_bresp = 2'b10;
        run_txn(32'h400, 8'd1, FOUR_BYTES, BURST_INCR, 1'b0, 32'h1234_0000, 0, 1'b1, 2'b10);
        slave_bresp = 2'b00;

        // Reset asserted while beat 2 is on the bus.
        push_expect(32'h500, 8'd3, FOUR_BYTES, BURST_INCR, 32'h5500_0000, 2);
        issue_cmd(32'h500, 8'd3, FOUR_BYTES, BURST_INCR, hc);
        send_beats(2, 32'h5500_0000, 0);
        saved    = done_seen;
        wr_valid = 1'b1;
        wr_data  = 32'h5500_0002;
        wr_strb  = strb_of(2);
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        chk_eq("postrst_awvalid", awvalid, 1'b0);
        chk_eq("postrst_wvalid", wvalid, 1'b0);
        chk_eq("postrst_bready", bready, 1'b0);
        chk_eq("postrst_done_valid", done_valid, 1'b0);
        chk_eq("postrst_cmd_ready", cmd_ready, 1'b1);
        chk_eq("postrst_wr_ready", wr_ready, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk_eq("postrst_no_done", done_seen, saved);

        // Recovery after reset.
        run_txn(32'h600, 8'd3, FOUR_BYTES, BURST_INCR, 1'b0, 32'h6600_0000, 0, 1'b1, 2'b00);

        chk_eq("aw_queue_empty", exp_aw.size(), 0);
        chk_eq("w_queue_empty", exp_w.size(), 0);
        chk_eq("done_queue_empty", exp_done.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_wr_master.md
Name: axi_wr_master

Overview:
- AXI4 write-channel initiator: the other end of the write path of the dual-port memory slave.
- Accepts one burst command plus a beat stream from local logic, and drives AW, W and B.
- Reports the write response to the issuer, with one transaction outstanding at a time.
- Used by the memory test harness and by future DMA-style clients of axi_dpmem.

Parameters:
- BOUNDARY_BYTES, 4096: INCR bursts must not cross a boundary of this many bytes; power of two.
- CHECK_EN, 1: when 0, the legality checks are skipped and every command is issued on the bus.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command handshake
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  AXI_ADDR_WIDTH  burst start address
- cmd_len  in  AXI_LEN_WIDTH  beats minus one
- cmd_size  in  AXI_SIZE_WIDTH  size_enum_t
- cmd_burst  in  AXI_BURST_WIDTH  burst_enum_t
- wr_valid  in  1  data-stream beat valid
- wr_ready  out  1  data-stream beat accepted
- wr_data  in  AXI_DATA_WIDTH  beat data
- wr_strb  in  AXI_STRB_WIDTH  beat strobes
- awaddr, awlen, awsize, awburst  out  as cmd_*  AW payload, registered
- awvalid  out  1
- awready  in  1
- wdata, wstrb  out  as wr_*  passed through from the stream
- wlast  out  1
- wvalid  out  1
- wready  in  1
- bresp  in  2
- bvalid  in  1
- bready  out  1
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  BRESP, or 2'b10 for a locally rejected command

Behaviour:
- Reset:
  - state=IDLE; awvalid=0, bready=0, done_valid=0, done_resp=0, beat counter=0.
  - AW payload registers cleared to 0.
  - cmd_ready=0 while rst is high; wvalid=0 and wr_ready=0 outside DATA.
- FSM states: IDLE, CHECK, ADDR, DATA, RESP, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch all cmd_* fields and go to CHECK.
- CHECK (one cycle) raises an error when any of the following holds:
  - burst==RESERVED (2'b11).
  - WRAP with (len+1) not in {2,4,8,16}, or addr not aligned to 2^size.
  - 2^size bytes greater than the bus width in bytes.
  - INCR where addr and (addr + ((len+1)<<size) - 1) differ in bits above log2(BOUNDARY_BYTES).
    - The sum is computed in AXI_ADDR_WIDTH+1 bits.
    - Overflow beyond address space is also an error.
- CHECK transitions:
  - Error: go to DONE with done_resp=2'b10, and no AW/W/B activity.
  - No error: go to ADDR.
- ADDR:
  - awvalid=1, with the payload held stable until awready.
  - The AW handshake moves to DATA; awvalid deasserts the following cycle.
- DATA:
  - wvalid = wr_valid; wr_ready = wready.
  - Beat counter counts up from 0; wlast = (count == latched len).
  - Each wvalid&&wready increments the counter.
  - The handshake with wlast goes to RESP.
  - Stalls on either side simply hold; wdata/wstrb are never altered.
- RESP:
  - bready=1.
  - On bvalid, capture bresp into done_resp and go to DONE.
- DONE: done_valid=1 for exactly one cycle, then IDLE. A new command can be accepted the next cycle.
- Latency with zero-wait slave and stream, N beats: cmd handshake to done_valid = 4+N cycles (CHECK 1, AW 1, N beats, B 1, DONE 1).
- len=0: a single beat with wlast=1 on the first beat.
- FIXED bursts are passed unmodified; address generation per beat is the slave's job.
- rst asserted mid-transaction:
  - All state is abandoned at the next edge and no done_valid is produced.
  - The bus is left to system reset.
- Simultaneous events: awready arriving in the same cycle as awvalid first rises completes AW in that cycle. W beats are not issued before the AW handshake.

Decomposition:
- Add to axi_pkg:
  - resp_t (2 bits) and resp_enum_t: OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11.
  - wr_mst_state_t enum.
  - A burst-legality function: addr, len, size, burst, boundary -> error bit.
- One natural sub-module: axi_burst_check (combinational legality check). The function may serve as its body.

Test Plan:
- INCR, addr=0x100, len=3, size=FOUR_BYTES, zero-wait slave -> 4 beats, wlast on beat 3 only, done_resp=00, done_valid 8 cycles after the command handshake.
- Same burst with awready delayed 5 cycles, wready low on beat 1 for 3 cycles, and wr_valid gaps -> AW payload stable, data order preserved, exactly 4 W handshakes.
- INCR, addr=0xFF8, len=3, size=FOUR_BYTES (crosses 0x1000) -> no awvalid, done_resp=10 at cycle 2.
- WRAP, len=2 -> rejected with 10; WRAP, addr=0x104, len=3, size=4B -> issued, awburst=10.
- burst=2'b11 -> rejected; slave returns bresp=SLVERR on a legal burst -> done_resp=10.
- rst pulsed during DATA beat 2 -> next cycle awvalid=wvalid=bready=0, cmd_ready=1 once rst is low, no done_valid.
